// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a binary source and the BCD converter.
// The converter takes the slave side; the source/consumer takes the master side.
interface bin2bcd_seq_if #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) ();
    logic                  i_start;
    logic [BIN_WIDTH-1:0]  i_bin;
    logic                  o_busy;
    logic                  o_done;
    logic [DIGITS*4-1:0]   o_digits;
    logic                  o_overflow;

    modport master (
        output i_start,
        output i_bin,
        input  o_busy,
        input  o_done,
        input  o_digits,
        input  o_overflow
    );

    modport slave (
        input  i_start,
        input  i_bin,
        output o_busy,
        output o_done,
        output o_digits,
        output o_overflow
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Result and overflow flag are held between commits so a downstream display never sees partial values.
module bin2bcd_seq #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) (
    input  logic            i_clk_10mhz,
    input  logic            i_rst,
    bin2bcd_seq_if.slave    bus
);
    localparam int SW = DIGITS * 4;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic {IDLE, CONVERT} state_t;

    // 10^n at BIN_WIDTH+1 bits, saturating to all-ones so an unreachable
    // threshold can never match a BIN_WIDTH-bit input.
    function automatic logic [BIN_WIDTH:0] pow10_sat(input int n);
        logic [BIN_WIDTH+4:0] acc;
        logic [BIN_WIDTH+4:0] lim;
        acc    = '0;
        acc[0] = 1'b1;
        lim    = {4'b0000, {(BIN_WIDTH+1){1'b1}}};
        for (int i = 0; i < n; i++) begin
            acc = acc * (BIN_WIDTH+5)'(10);
            if (acc > lim) acc = lim;
        end
        return acc[BIN_WIDTH:0];
    endfunction

    localparam logic [BIN_WIDTH:0] LIMIT = pow10_sat(DIGITS);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          scratch_q, scratch_d;
    logic [BIN_WIDTH-1:0]   bin_q, bin_d;
    logic                   sticky_q, sticky_d;
    logic                   cmp_q, cmp_d;
    logic [SW-1:0]          digits_q, digits_d;
    logic                   ovf_q, ovf_d;
    logic                   done_q, done_d;

    logic [SW-1:0]          adj;
    logic [SW-1:0]          shift_scr;
    logic [BIN_WIDTH-1:0]   shift_bin;
    logic [DIGITS-1:0]      nib_gt9;
    logic                   ovf_any;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                    scratch_q[gi*4 +: 4] + 4'd3 :
                                    scratch_q[gi*4 +: 4];
            assign nib_gt9[gi] = (shift_scr[gi*4 +: 4] > 4'd9);
        end
    endgenerate

    assign shift_scr = {adj[SW-2:0], bin_q[BIN_WIDTH-1]};
    assign shift_bin = {bin_q[BIN_WIDTH-2:0], 1'b0};

    always_ff @(posedge i_clk_10mhz or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            scratch_q <= '0;
            bin_q     <= '0;
            sticky_q  <= 1'b0;
            cmp_q     <= 1'b0;
            digits_q  <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            scratch_q <= scratch_d;
            bin_q     <= bin_d;
            sticky_q  <= sticky_d;
            cmp_q     <= cmp_d;
            digits_q  <= digits_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        scratch_d = scratch_q;
        bin_d     = bin_q;
        sticky_d  = sticky_q;
        cmp_d     = cmp_q;
        digits_d  = digits_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        ovf_any   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    bin_d     = bus.i_bin;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    cmp_d     = ({1'b0, bus.i_bin} >= LIMIT);
                    cnt_d     = CW'(BIN_WIDTH);
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = shift_scr;
                bin_d     = shift_bin;
                sticky_d  = sticky_q | adj[SW-1];
                cnt_d     = cnt_q - CW'(1);
                // Last iteration: commit the result in the same edge.
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_any = sticky_d | cmp_q;
                    ovf_d   = ovf_any;
                    if (!ovf_any || (|nib_gt9)) digits_d = shift_scr;
                    else                        digits_d = {DIGITS{4'd9}};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_busy     = (state_q == CONVERT);
    assign bus.o_done     = done_q;
    assign bus.o_digits   = digits_q;
    assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq: latency, boundaries, busy-ignore, back-to-back, mid-conversion reset.
module tb_bin2bcd_seq;
    localparam int BW = 27;
    localparam int DG = 8;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    bin2bcd_seq_if #(.BIN_WIDTH(BW), .DIGITS(DG)) bus ();

    bin2bcd_seq #(.BIN_WIDTH(BW), .DIGITS(DG)) dut (
        .i_clk_10mhz (clk),
        .i_rst       (rst),
        .bus         (bus.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic start_conv(input logic [BW-1:0] v);
        @(negedge clk);
        bus.i_bin   = v;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
    endtask

    // Counts edges from the accepting edge until o_done, plus busy samples and digit stability.
    task automatic wait_done(output int lat, output int nbusy, output bit stable);
        logic [DG*4-1:0] held;
        held   = bus.o_digits;
        lat    = 0;
        nbusy  = 0;
        stable = 1'b1;
        while (!bus.o_done && lat < 100) begin
            if (bus.o_busy) nbusy++;
            if (bus.o_digits !== held) stable = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [BW-1:0]   bin;
        logic [31:0]     bcd;
        logic            ovf;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  lat, nbusy, ndone;
        bit  stable;
        errors = 0;
        checks = 0;
        bus.i_start = 1'b0;
        bus.i_bin   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_digits", bus.o_digits, 0);
        check("rst_busy",   bus.o_busy, 0);
        check("rst_done",   bus.o_done, 0);
        check("rst_ovf",    bus.o_overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic conversion plus boundaries
        vecs[0] = '{27'd12345678,  32'h12345678, 1'b0};
        vecs[1] = '{27'd0,         32'h00000000, 1'b0};
        vecs[2] = '{27'd99999999,  32'h99999999, 1'b0};
        vecs[3] = '{27'd100000000, 32'h99999999, 1'b1};
        vecs[4] = '{27'd134217727, 32'h99999999, 1'b1};
        foreach (vecs[i]) begin
            start_conv(vecs[i].bin);
            wait_done(lat, nbusy, stable);
            $display("conv %0d -> digits=%h ovf=%0b lat=%0d", vecs[i].bin, bus.o_digits, bus.o_overflow, lat);
            check("latency", lat, 27);
            check("busy_cycles", nbusy, 27);
            check("stable", stable, 1);
            check("digits", bus.o_digits, vecs[i].bcd);
            check("ovf", bus.o_overflow, vecs[i].ovf);
            @(posedge clk);
            #1;
            check("done_width", bus.o_done, 0);
        end

        // Start while busy is ignored
        start_conv(27'd42);
        ndone = 0;
        for (int e = 1; e <= 40; e++) begin
            if (e == 10) begin
                bus.i_bin   = 27'd7;
                bus.i_start = 1'b1;
            end else begin
                bus.i_start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.o_done) begin
                ndone++;
                check("busy_ign_lat", e, 27);
            end
        end
        bus.i_start = 1'b0;
        $display("busy-start: ndone=%0d digits=%h", ndone, bus.o_digits);
        check("busy_ign_ndone", ndone, 1);
        check("busy_ign_digits", bus.o_digits, 32'h00000042);

        // Back-to-back: new request in the done cycle
        start_conv(27'd1000);
        wait_done(lat, nbusy, stable);
        check("b2b_first", bus.o_digits, 32'h00001000);
        bus.i_bin   = 27'd9;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        check("b2b_busy", bus.o_busy, 1);
        wait_done(lat, nbusy, stable);
        $display("back-to-back: digits=%h gap=%0d", bus.o_digits, lat);
        check("b2b_gap", lat, 27);
        check("b2b_stable", stable, 1);
        check("b2b_second", bus.o_digits, 32'h00000009);

        // Reset mid-conversion
        start_conv(27'd555);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_digits", bus.o_digits, 0);
        check("mid_rst_busy",   bus.o_busy, 0);
        check("mid_rst_done",   bus.o_done, 0);
        check("mid_rst_ovf",    bus.o_overflow, 0);
        ndone = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (bus.o_done) ndone++;
            if (e == 2) begin
                @(negedge clk);
                rst = 1'b0;
            end
        end
        $display("mid-reset: done pulses after abort=%0d", ndone);
        check("mid_rst_nodone", ndone, 0);
        start_conv(27'd555);
        wait_done(lat, nbusy, stable);
        $display("after reset: digits=%h", bus.o_digits);
        check("post_rst_digits", bus.o_digits, 32'h00000555);
        check("post_rst_lat", lat, 27);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the multiplexed 7-segment driver. Its packed BCD output connects straight to the driver's digit input.
- Lets counters and other binary sources drive the display as decimal.
- Output is held stable between conversions, so the display never shows a partial result.

Parameters:
- BIN_WIDTH, 27: width of the binary input. 27 bits covers 0..134,217,727.
- DIGITS, 8: number of BCD digits produced. Must match the display driver's DIGITS.

Ports:
- i_clk_10mhz  input  1  system clock, 10 MHz; all logic on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  conversion request; sampled on the rising edge.
- i_bin  input  BIN_WIDTH  unsigned binary value; sampled on the edge that accepts i_start.
- o_busy  output  1  high while a conversion is in progress.
- o_done  output  1  one-cycle pulse when a new result is written to o_digits.
- o_digits  output  DIGITS*4  packed BCD result. Digit 0 (least significant) is in bits [3:0]. Held until the next completion.
- o_overflow  output  1  high when the last accepted value exceeded 10^DIGITS - 1. Updated together with o_digits.

Behaviour:
- Reset is asynchronous and active-high. While asserted, or on assertion:
  - o_digits = 0, o_busy = 0, o_done = 0, o_overflow = 0.
  - State = IDLE, iteration counter = 0, internal shift register = 0.
- States:
  - IDLE: o_busy = 0. If i_start = 1 at an edge, capture i_bin into the shift register, clear the BCD scratch register and the sticky overflow bit, load counter = BIN_WIDTH, go to CONVERT.
  - CONVERT: o_busy = 1. Each edge performs one iteration:
    - Add 3 to every scratch nibble whose value is >= 5.
    - Shift the {scratch, binary} register left by 1.
    - If the bit shifted out of the top scratch nibble is 1, set the sticky overflow bit.
    - Decrement the counter.
    - The iteration that brings the counter to 0 also commits the result (see below) and returns to IDLE.
- Commit, on the final iteration edge:
  - If overflow is clear, or the final scratch value exceeds 9 in any nibble: o_digits = scratch.
  - Otherwise o_digits saturates to all nibbles = 9, and o_overflow = 1.
  - o_done = 1 for exactly one cycle.
  - Overflow is determined by the sticky bit together with a final compare of i_bin >= 10^DIGITS, computed at capture and registered. Either condition forces saturation.
- Latency:
  - i_start accepted at edge k.
  - o_busy is high from after edge k until after edge k+BIN_WIDTH.
  - o_done and new o_digits are visible after edge k+BIN_WIDTH.
- Throughput: the cycle in which o_done = 1 is an IDLE cycle, so i_start is accepted there. Back-to-back conversions complete every BIN_WIDTH cycles.
- i_start while o_busy = 1 is ignored. There is no queueing, and the conversion in progress is unaffected.
- Changes to i_bin after capture have no effect on the conversion in progress.
- o_digits and o_overflow change only on a commit edge or on reset. They are stable on every other cycle.
- Reset asserted mid-conversion aborts immediately. The partial result is discarded, no o_done pulse is produced, and o_digits = 0.
- Widths:
  - Scratch register is DIGITS*4 bits; nibble add-3 is done at 4-bit width.
  - The 10^DIGITS constant is evaluated at elaboration at width BIN_WIDTH+1.
  - If 10^DIGITS > 2^BIN_WIDTH, overflow can never assert.

Test Plan (DIGITS=8, BIN_WIDTH=27):
1. Basic conversion: reset, then i_bin = 12,345,678 with a 1-cycle i_start → o_busy high for 27 cycles; o_done pulses 27 edges after the start edge; o_digits = 'h12345678; o_overflow = 0.
2. Boundaries:
   - i_bin = 0 → o_digits = 'h00000000.
   - i_bin = 99,999,999 → 'h99999999, o_overflow = 0.
   - i_bin = 100,000,000 → 'h99999999, o_overflow = 1.
   - i_bin = 134,217,727 → 'h99999999, o_overflow = 1.
3. Start while busy: convert 42, pulse i_start with i_bin = 7 at cycle 10 of the conversion → exactly one o_done pulse; o_digits = 'h00000042; the second request is ignored.
4. Back-to-back: assert i_start in the o_done cycle with i_bin = 9 after converting 1000 → results 'h00001000 then 'h00000009; done pulses 27 cycles apart; o_digits is stable between them.
5. Reset mid-operation: assert i_rst at cycle 13 of a conversion of 555 → all outputs 0 immediately; no o_done pulse; the next conversion of 555 yields 'h00000555.
6. Integration: drive o_digits into the display driver with a free-running converter → the driver's segment/anode outputs show the committed digits, with no glitch during conversion.
